// File: rtl/mult_dispatcher_pkg.sv
// Shared types for the multiplier dispatcher: FSM states and the queued operand pair.
package mult_pkg;

  localparam int TAMANO_DEF = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT} disp_state_t;

  typedef struct packed {
    logic [TAMANO_DEF-1:0] A;
    logic [TAMANO_DEF-1:0] B;
  } operand_pair_t;

endpackage

// File: rtl/mult_dispatcher_sync_fifo.sv
// Small synchronous FIFO with registered pointers; push is accepted at full only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && (!full_o || pop_i);
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (!doPush && doPop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/mult_dispatcher.sv
// Front end for the shift-and-add multiplier: queues operand pairs, runs one job at a time,
// holds the product in a single result slot, and flags jobs that never finish.
module mult_dispatcher
  import mult_pkg::*;
#(
  parameter int tamano     = TAMANO_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [tamano-1:0]   IN_A,
  input  logic [tamano-1:0]   IN_B,
  output logic [tamano-1:0]   MULT_A,
  output logic [tamano-1:0]   MULT_B,
  output logic                MULT_START,
  input  logic                MULT_END,
  input  logic [2*tamano-1:0] MULT_S,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [2*tamano-1:0] OUT_S,
  output logic                ERR,
  output logic [7:0]          JOB_CNT
);

  localparam int PAIR_W = 2 * tamano;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  disp_state_t         state_q, state_d;
  logic [tamano-1:0]   opA_q, opA_d, opB_q, opB_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                outValid_q, outValid_d;
  logic [PAIR_W-1:0]   outS_q, outS_d;
  logic                err_q, err_d;
  logic [7:0]          jobCnt_q, jobCnt_d;
  logic                fifoFull, fifoEmpty, fifoPop;
  logic [PAIR_W-1:0]   fifoDout;

  sync_fifo #(.WIDTH(PAIR_W), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk_i   (CLOCK),
    .reset_i (RESET),
    .push_i  (IN_VALID && IN_READY),
    .pop_i   (fifoPop),
    .din_i   ({IN_A, IN_B}),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign IN_READY   = !fifoFull;
  assign MULT_A     = opA_q;
  assign MULT_B     = opB_q;
  assign MULT_START = (state_q == ISSUE);
  assign OUT_VALID  = outValid_q;
  assign OUT_S      = outS_q;
  assign ERR        = err_q;
  assign JOB_CNT    = jobCnt_q;

  // Timer reads 0 in ISSUE and k in the k-th cycle after START; a job still waiting when
  // it would reach TIMEOUT is dropped. ARM exists to skip a stale END from the last job.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    timer_d    = timer_q;
    outValid_d = outValid_q && !OUT_READY;
    outS_d     = outS_q;
    err_d      = err_q;
    jobCnt_d   = jobCnt_q;
    fifoPop    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifoEmpty && !outValid_q) begin
          fifoPop = 1'b1;
          opA_d   = fifoDout[PAIR_W-1:tamano];
          opB_d   = fifoDout[tamano-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + 1'b1;
        state_d = ARM;
      end
      ARM: begin
        timer_d = timer_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (MULT_END) begin
          outS_d     = MULT_S;
          outValid_d = 1'b1;
          jobCnt_d   = jobCnt_q + 8'd1;
          state_d    = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      timer_q    <= '0;
      outValid_q <= 1'b0;
      outS_q     <= '0;
      err_q      <= 1'b0;
      jobCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      timer_q    <= timer_d;
      outValid_q <= outValid_d;
      outS_q     <= outS_d;
      err_q      <= err_d;
      jobCnt_q   <= jobCnt_d;
    end
  end

endmodule
